lfsr_scrambler_gen: RTL

LFSR_SCRAMBLER_GEN -- requirements
Module: lfsr_scrambler_gen

---
 rtl/lfsr_scrambler_pkg.sv | 31 +++
 rtl/lfsr_step_unroll.sv | 31 +++
 rtl/lfsr_scrambler_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_scrambler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_scrambler_pkg
//  Description : Shared register map, CTRL bit positions, FSM encoding and
//                default feedback mask for the LFSR scrambler generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_scrambler_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [11:0] c_OFF_SEED   = 12'h000;
    localparam logic [11:0] c_OFF_CTRL   = 12'h010;
    localparam logic [11:0] c_OFF_PERIOD = 12'h011;
    localparam logic [11:0] c_OFF_STATUS = 12'h012;
    localparam logic [11:0] c_OFF_LIVE   = 12'h020;

    // CTRL bit positions
    localparam int c_CTRL_COMMIT = 0;
    localparam int c_CTRL_AUTO   = 1;
    localparam int c_CTRL_CLRZ   = 2;

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Default Galois feedback mask: bits 0, 43, 89, 110
    localparam logic [255:0] c_DEFAULT_TAPS =
        (256'd1 << 110) | (256'd1 << 89) | (256'd1 << 43) | 256'd1;

endpackage : lfsr_scrambler_pkg
`default_nettype wire

// File: rtl/lfsr_step_unroll.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_step_unroll
//  Description : Purely combinational NUM_OF_STEPS-deep chain of Galois LFSR
//                steps (shift left, fold the dropped MSB back through TAPS).
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step_unroll
    import lfsr_scrambler_pkg::*;
#(
    parameter int                    POLY_WIDTH   = 147,
    parameter logic [POLY_WIDTH-1:0] TAPS         = POLY_WIDTH'(c_DEFAULT_TAPS),
    parameter int                    NUM_OF_STEPS = 12
) (
    input  logic [POLY_WIDTH-1:0] i_state,
    output logic [POLY_WIDTH-1:0] o_state
);

    logic [POLY_WIDTH-1:0] w_chain [0:NUM_OF_STEPS];

    assign w_chain[0] = i_state;

    for (genvar gi = 0; gi < NUM_OF_STEPS; gi++) begin : g_step
        assign w_chain[gi+1] = {w_chain[gi][POLY_WIDTH-2:0], 1'b0}
                             ^ (w_chain[gi][POLY_WIDTH-1] ? TAPS : '0);
    end

    assign o_state = w_chain[NUM_OF_STEPS];

endmodule : lfsr_step_unroll
`default_nettype wire

// File: rtl/lfsr_scrambler_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_scrambler_gen
//  Description : Register-programmable wide Galois LFSR scrambler generator
//                with shadow seed, commit, periodic auto-reseed and
//                all-zero-state detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_scrambler_gen
    import lfsr_scrambler_pkg::*;
#(
    parameter int                    POLY_WIDTH   = 147,
    parameter logic [POLY_WIDTH-1:0] TAPS         = POLY_WIDTH'(c_DEFAULT_TAPS),
    parameter int                    NUM_OF_STEPS = 12,
    parameter logic [11:0]           BASE_ADDR    = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  write,
    input  logic                  read,
    input  logic [11:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic [POLY_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  zero_err,
    output logic                  reseed_pulse
);

    localparam int c_NW   = (POLY_WIDTH + 31) / 32;
    localparam int c_PADW = c_NW * 32;

    logic [0:0]            r_state;
    logic [POLY_WIDTH-1:0] r_live;
    logic [POLY_WIDTH-1:0] r_shadow;
    logic                  r_auto;
    logic [15:0]           r_period;
    logic [15:0]           r_count;
    logic                  r_zero_err;
    logic                  r_dout_valid;
    logic                  r_reseed_pulse;
    logic [31:0]           r_rdata;
    logic                  r_rdata_valid;

    logic [11:0]           w_off;
    logic                  w_run;
    logic                  w_ctrl_wr;
    logic                  w_commit;
    logic                  w_clr_zero;
    logic                  w_adv;
    logic                  w_reseed;
    logic                  w_wr_seed;
    logic [POLY_WIDTH-1:0] w_stepped;
    logic [c_PADW-1:0]     w_shadow_pad;
    logic [c_PADW-1:0]     w_live_pad;
    logic [c_PADW-1:0]     w_shadow_wr;
    logic [31:0]           w_rdata_next;

    // Offset is taken modulo the 12-bit address space so the window may wrap.
    assign w_off        = addr - BASE_ADDR;
    assign w_run        = (r_state == c_ST_RUN);
    assign w_ctrl_wr    = write && (w_off == c_OFF_CTRL);
    assign w_commit     = w_ctrl_wr && wdata[c_CTRL_COMMIT];
    assign w_clr_zero   = w_ctrl_wr && wdata[c_CTRL_CLRZ];
    // Commit outranks a same-cycle enable: the freshly loaded seed is not stepped.
    assign w_adv        = w_run && enable && !w_commit;
    assign w_reseed     = w_adv && r_auto && (r_period != 16'd0)
                        && (r_count == r_period - 16'd1);
    assign w_wr_seed    = write && (w_off < 12'(c_NW));
    assign w_shadow_pad = c_PADW'(r_shadow);
    assign w_live_pad   = c_PADW'(r_live);

    lfsr_step_unroll #(
        .POLY_WIDTH   (POLY_WIDTH),
        .TAPS         (TAPS),
        .NUM_OF_STEPS (NUM_OF_STEPS)
    ) u_step (
        .i_state (r_live),
        .o_state (w_stepped)
    );

    // Merge an incoming seed word into the padded shadow image.
    always_comb begin
        w_shadow_wr = w_shadow_pad;
        for (int k = 0; k < c_NW; k++) begin
            if (w_off == 12'(k)) w_shadow_wr[32*k +: 32] = wdata;
        end
    end

    // Read mux built from pre-write register contents.
    always_comb begin
        w_rdata_next = '0;
        for (int k = 0; k < c_NW; k++) begin
            if (w_off == c_OFF_SEED + 12'(k)) w_rdata_next = w_shadow_pad[32*k +: 32];
            if (w_off == c_OFF_LIVE + 12'(k)) w_rdata_next = w_live_pad[32*k +: 32];
        end
        if (w_off == c_OFF_CTRL)   w_rdata_next[c_CTRL_AUTO] = r_auto;
        if (w_off == c_OFF_PERIOD) w_rdata_next = {16'd0, r_period};
        if (w_off == c_OFF_STATUS) w_rdata_next = {r_count, 14'd0, w_run, r_zero_err};
    end

    // FSM: leaves IDLE on the first commit and stays in RUN until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_state <= c_ST_IDLE;
        else if (w_commit) r_state <= c_ST_RUN;
    end

    // Live LFSR state: load from shadow on commit/reseed, otherwise step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_live <= '0;
        else if (w_commit || w_reseed)  r_live <= r_shadow;
        else if (w_adv)                 r_live <= w_stepped;
    end

    // Enabled-cycle counter; cleared on load, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_count <= '0;
        else if (w_commit || w_reseed)               r_count <= '0;
        else if (w_adv && (r_count != 16'hFFFF))     r_count <= r_count + 16'd1;
    end

    // Programming registers: shadow seed, auto-reseed enable, period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_auto   <= 1'b0;
            r_period <= '0;
        end else begin
            if (w_wr_seed) r_shadow <= w_shadow_wr[POLY_WIDTH-1:0];
            if (w_ctrl_wr) r_auto   <= wdata[c_CTRL_AUTO];
            if (write && (w_off == c_OFF_PERIOD)) r_period <= wdata[15:0];
        end
    end

    // Status flags; a zero-state detection beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero_err     <= 1'b0;
            r_dout_valid   <= 1'b0;
            r_reseed_pulse <= 1'b0;
        end else begin
            if (w_run && enable && (r_live == '0)) r_zero_err <= 1'b1;
            else if (w_clr_zero)                   r_zero_err <= 1'b0;
            r_dout_valid   <= w_commit || (w_run && enable);
            r_reseed_pulse <= w_reseed;
        end
    end

    // Registered read port with a one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= read;
            if (read) r_rdata <= w_rdata_next;
        end
    end

    assign dout         = r_live;
    assign dout_valid   = r_dout_valid;
    assign zero_err     = r_zero_err;
    assign reseed_pulse = r_reseed_pulse;
    assign rdata        = r_rdata;
    assign rdata_valid  = r_rdata_valid;

endmodule : lfsr_scrambler_gen
`default_nettype wire
